i2s_dac_sched: RTL and testbench
================================

// Module: i2s_dac_sched
// PURPOSE
//  Frame scheduler/arbiter in front of the I2S DAC serializer (aud_bclk domain).
//  Tracks aud_lrc frames and fetches one stereo pair per frame from one of two
//  upstream sources via valid/ready, with fixed-priority or round-robin selection.
//  Presents the per-channel word for the serializer and handles underrun, mute
//  and LRC loss.
// PARAMETERS
//  WL        16    sample word length (bits)
//  RR        0     0: src0 has fixed priority; 1: round-robin between sources
//  HOLD_LAST 1     on underrun: 1 repeats last pair, 0 outputs zeros
//  TMO_CYC   256   bclk cycles without an LRC edge before returning to SYNC
//  CNT_W     16    width of the saturating underrun counter
// PORTS
//  aud_bclk      in   1      I2S bit clock, sole clock
//  rst_n         in   1      reset, asynchronous, active-low
//  aud_lrc       in   1      LR clock (0 = left, 1 = right)
//  src_en        in   2      per-source enable, sampled at frame start
//  mute          in   1      force zero output, sampled at frame start
//  src0_valid    in   1      src0 stereo pair available
//  src0_ready    out  1      src0 pair consumed (1-cycle pulse)
//  src0_left     in   WL     src0 left sample (signed)
//  src0_right    in   WL     src0 right sample (signed)
//  src1_valid/src1_ready/src1_left/src1_right   same as src0
//  dac_data      out  WL     word for serializer, current channel
//  frame_start   out  1      1-cycle pulse, cycle after left-frame start
//  grant         out  2      one-hot source of current pair; 00 = none
//  underrun      out  1      1-cycle pulse on underrun frame
//  underrun_cnt  out  CNT_W  saturating underrun count
// BEHAVIOUR
//  - Reset: all outputs 0, lrc_d=1, state SYNC, last pair=0, RR pointer=src0.
//  - Edges: lrc_d registers aud_lrc each posedge.
//    fall = lrc_d & ~aud_lrc, rise = ~lrc_d & aud_lrc.
//  - FSM SYNC: dac_data=0, no fetch; fall -> fetch, go LEFT. rise ignored.
//  - LEFT: rise -> RIGHT; dac_data <= held right sample.
//  - RIGHT: fall -> fetch, go LEFT.
//  - Fetch (fall cycle in SYNC or RIGHT):
//    - Candidate = src_en[i] & srcN_valid.
//    - RR=0: src0 wins over src1. RR=1: pointer side wins; pointer toggles after each grant.
//    - Winner's ready=1 that cycle only. Transfer = valid&ready; sources hold data while valid.
//    - Next cycle: grant=winner, frame_start=1, pair latched.
//    - dac_data <= winner left, or 0 if mute=1. A muted pair is still consumed.
//  - Underrun: no candidate while src_en != 00.
//    - No ready, grant=00, underrun pulse, counter +1 saturating at all ones.
//    - dac_data/pair: last pair (HOLD_LAST=1) or zeros (HOLD_LAST=0).
//  - src_en==00: idle frame, zeros output, no underrun counted.
//  - mute, src_en, grant change only at fetch; mid-frame changes take effect next frame.
//  - Watchdog: counter clears on any edge, else increments.
//    - At TMO_CYC-1 -> SYNC, dac_data=0, grant=00; no readys until next fall.
//  - Latency: fall cycle -> dac_data/grant/frame_start valid on next posedge.
//    rise cycle -> right word on next posedge.
//  - Both valids with RR=0: only src0 ready; src1 stays pending.
//  - rst_n mid-frame: immediate return to reset values; an in-flight ready is dropped (not consumed).
// TESTING
//  1. src0 valid, pair (0x1234, 0xABCD), src_en=01, 4 frames
//     -> dac_data 0x1234 in left / 0xABCD in right; src0_ready one pulse per fall; grant=01.
//  2. RR=1, both valid, src_en=11, 4 frames
//     -> grant 01,10,01,10; ready pulses alternate.
//  3. RR=0, both valid -> grant always 01.
//     Drop src0_valid -> grant=10 from the next frame.
//  4. Underrun: src_en=01, src0_valid=0 after pair (0x0100, 0x0200)
//     -> HOLD_LAST=1 repeats 0x0100/0x0200; HOLD_LAST=0 gives 0.
//     underrun pulses; counter 1,2,3; saturates when CNT_W=2 at 3.
//  5. mute=1 asserted mid-frame -> takes effect next fall.
//     dac_data=0, ready still pulses.
//  6. Hold aud_lrc constant 300 cycles -> SYNC by cycle 256, dac_data=0.
//     Resume -> first fetch on first fall. Also assert rst_n mid-frame -> outputs 0 immediately.

Source files
------------

// File: rtl/i2s_dac_sched.sv
// i2s_dac_sched: frame scheduler/arbiter feeding the I2S DAC serializer.
// Follows aud_lrc frames. Each left-frame start fetches one stereo pair
// from src0 or src1, using fixed priority or round-robin. The block then
// presents the left word and, after the LRC rise, the right word.
// It also handles underrun, mute and loss of LRC (watchdog back to SYNC).
// Ports:
//   aud_bclk, rst_n        bit clock, async active-low reset
//   aud_lrc                LR clock (0 = left, 1 = right)
//   src_en, mute           per-frame controls, sampled at fetch
//   srcN_valid/ready       per-source handshake (ready = 1-cycle pulse)
//   srcN_left/right        per-source stereo pair
//   dac_data               word for the current channel
//   frame_start, grant     fetch pulse and one-hot source of current pair
//   underrun, underrun_cnt underrun pulse and saturating count
module i2s_dac_sched #(
  parameter int unsigned WL        = 16,
  parameter int unsigned RR        = 0,
  parameter int unsigned HOLD_LAST = 1,
  parameter int unsigned TMO_CYC   = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             aud_bclk,
  input  logic             rst_n,
  input  logic             aud_lrc,
  input  logic [1:0]       src_en,
  input  logic             mute,
  input  logic             src0_valid,
  output logic             src0_ready,
  input  logic [WL-1:0]    src0_left,
  input  logic [WL-1:0]    src0_right,
  input  logic             src1_valid,
  output logic             src1_ready,
  input  logic [WL-1:0]    src1_left,
  input  logic [WL-1:0]    src1_right,
  output logic [WL-1:0]    dac_data,
  output logic             frame_start,
  output logic [1:0]       grant,
  output logic             underrun,
  output logic [CNT_W-1:0] underrun_cnt
);

  localparam int unsigned     WD_W   = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TMO_CYC - 1);

  typedef enum logic [1:0] { ST_SYNC, ST_LEFT, ST_RIGHT } state_t;

  state_t          state_q;
  logic            lrc_q;
  logic            rr_ptr_q;
  logic [WD_W-1:0] wd_q;
  logic [WL-1:0]   last_l_q, last_r_q;  // last consumed pair, replayed on underrun
  logic [WL-1:0]   right_q;             // right word of the current frame

  logic          fall, rise, fetch, timeout;
  logic [1:0]    cand, win;
  logic [WL-1:0] sel_l, sel_r;

  always_comb begin
    fall    = lrc_q & ~aud_lrc;
    rise    = ~lrc_q & aud_lrc;
    fetch   = fall && (state_q != ST_LEFT);
    timeout = !(fall || rise) && (wd_q == WD_MAX);
    cand    = src_en & {src1_valid, src0_valid};
    win     = 2'b00;
    if ((RR != 0) && rr_ptr_q) begin
      if (cand[1])      win = 2'b10;
      else if (cand[0]) win = 2'b01;
    end else begin
      if (cand[0])      win = 2'b01;
      else if (cand[1]) win = 2'b10;
    end
    sel_l = win[1] ? src1_left  : src0_left;
    sel_r = win[1] ? src1_right : src0_right;
    // Gating with rst_n drops a handshake that is in flight when reset hits.
    src0_ready = rst_n & fetch & win[0];
    src1_ready = rst_n & fetch & win[1];
  end

  always_ff @(posedge aud_bclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SYNC;
      lrc_q        <= 1'b1;
      rr_ptr_q     <= 1'b0;
      wd_q         <= '0;
      last_l_q     <= '0;
      last_r_q     <= '0;
      right_q      <= '0;
      dac_data     <= '0;
      frame_start  <= 1'b0;
      grant        <= 2'b00;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      lrc_q       <= aud_lrc;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (fall || rise)        wd_q <= '0;
      else if (wd_q != WD_MAX) wd_q <= wd_q + 1'b1;

      if (timeout) begin
        state_q  <= ST_SYNC;
        dac_data <= '0;
        grant    <= 2'b00;
      end else if (fetch) begin
        state_q     <= ST_LEFT;
        frame_start <= 1'b1;
        grant       <= win;
        if (win != 2'b00) begin
          if (RR != 0) rr_ptr_q <= ~rr_ptr_q;
          last_l_q <= sel_l;
          last_r_q <= sel_r;
          dac_data <= mute ? '0 : sel_l;
          right_q  <= mute ? '0 : sel_r;
        end else if (src_en != 2'b00) begin
          underrun <= 1'b1;
          if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
          if ((HOLD_LAST != 0) && !mute) begin
            dac_data <= last_l_q;
            right_q  <= last_r_q;
          end else begin
            dac_data <= '0;
            right_q  <= '0;
          end
        end else begin
          dac_data <= '0;
          right_q  <= '0;
        end
      end else if (rise && (state_q == ST_LEFT)) begin
        state_q  <= ST_RIGHT;
        dac_data <= right_q;
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_sched.sv
// Bench for i2s_dac_sched. Two instances share the stimulus:
// A is fixed priority with hold-last, B is round-robin with zero-fill and a 2-bit counter.
module tb_i2s_dac_sched;
  localparam int H = 8;  // bclk cycles per LRC half-frame

  logic        clk = 1'b0, rst_n = 1'b0, lrc = 1'b1, mute = 1'b0, v0 = 1'b0, v1 = 1'b0;
  logic [1:0]  src_en = 2'b00;
  logic [15:0] l0 = '0, r0 = '0, l1 = '0, r1 = '0;

  logic        a_r0, a_r1, a_fs, a_ur, b_r0, b_r1, b_fs, b_ur;
  logic [15:0] a_dac, b_dac, a_cnt;
  logic [1:0]  a_g, b_g, b_cnt;

  int errors = 0, checks = 0;

  // reference model state and per-frame expectations, index 0 = A, 1 = B
  int          ptr[2], cnt[2], e_cnt[2];
  logic [15:0] last_l[2], last_r[2], e_l[2], e_r[2];
  logic [1:0]  e_g[2];
  logic        e_ur[2];
  // snapshots and per-frame observations
  logic        c_r0[2], c_r1[2], c_fs[2], c_ur[2];
  logic [1:0]  c_g[2];
  logic [15:0] c_dac[2];
  int          c_cnt[2];
  logic        o_r0[2], o_r1[2], o_fs[2], o_ur[2];
  logic [1:0]  o_g[2];
  logic [15:0] o_l[2], o_r[2];
  int          o_cnt[2], o_stray[2];

  always #5 clk = ~clk;

  i2s_dac_sched #(.WL(16), .RR(0), .HOLD_LAST(1), .TMO_CYC(256), .CNT_W(16)) dut_a (
    .aud_bclk(clk), .rst_n(rst_n), .aud_lrc(lrc), .src_en(src_en), .mute(mute),
    .src0_valid(v0), .src0_ready(a_r0), .src0_left(l0), .src0_right(r0),
    .src1_valid(v1), .src1_ready(a_r1), .src1_left(l1), .src1_right(r1),
    .dac_data(a_dac), .frame_start(a_fs), .grant(a_g), .underrun(a_ur), .underrun_cnt(a_cnt));

  i2s_dac_sched #(.WL(16), .RR(1), .HOLD_LAST(0), .TMO_CYC(256), .CNT_W(2)) dut_b (
    .aud_bclk(clk), .rst_n(rst_n), .aud_lrc(lrc), .src_en(src_en), .mute(mute),
    .src0_valid(v0), .src0_ready(b_r0), .src0_left(l0), .src0_right(r0),
    .src1_valid(v1), .src1_ready(b_r1), .src1_left(l1), .src1_right(r1),
    .dac_data(b_dac), .frame_start(b_fs), .grant(b_g), .underrun(b_ur), .underrun_cnt(b_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    c_r0[0] = a_r0;  c_r1[0] = a_r1;  c_fs[0] = a_fs;  c_ur[0] = a_ur;
    c_g[0]  = a_g;   c_dac[0] = a_dac; c_cnt[0] = int'(a_cnt);
    c_r0[1] = b_r0;  c_r1[1] = b_r1;  c_fs[1] = b_fs;  c_ur[1] = b_ur;
    c_g[1]  = b_g;   c_dac[1] = b_dac; c_cnt[1] = int'(b_cnt);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ptr[d] = 0; cnt[d] = 0; last_l[d] = '0; last_r[d] = '0;
    end
  endtask

  // Frame-level reference: what each instance should present for the frame
  // that starts with the fall about to be driven.
  task automatic model_fetch();
    logic [1:0] cand;
    int w, mx;
    cand = src_en & {v1, v0};
    for (int d = 0; d < 2; d++) begin
      mx = (d == 0) ? 65535 : 3;
      e_ur[d] = 1'b0; e_g[d] = 2'b00; e_l[d] = '0; e_r[d] = '0;
      if (src_en != 2'b00) begin
        if (cand == 2'b00) begin
          e_ur[d] = 1'b1;
          if (cnt[d] < mx) cnt[d] = cnt[d] + 1;
          if (d == 0 && !mute) begin e_l[d] = last_l[d]; e_r[d] = last_r[d]; end
        end else begin
          if (d == 1 && ptr[d] == 1) w = cand[1] ? 1 : 0;
          else                       w = cand[0] ? 0 : 1;
          if (d == 1) ptr[d] = 1 - ptr[d];
          e_g[d]    = (w == 0) ? 2'b01 : 2'b10;
          last_l[d] = (w == 0) ? l0 : l1;
          last_r[d] = (w == 0) ? r0 : r1;
          if (!mute) begin e_l[d] = last_l[d]; e_r[d] = last_r[d]; end
        end
      end
      e_cnt[d] = cnt[d];
    end
  endtask

  // Drive one full LRC frame and record what both instances did.
  // o_stray counts cycles where a word moved or a pulse appeared off-schedule.
  task automatic do_frame(input bit mid_chg, input logic new_mute, input logic [1:0] new_en);
    model_fetch();
    lrc = 1'b0;
    #1;
    snap();
    for (int d = 0; d < 2; d++) begin o_r0[d] = c_r0[d]; o_r1[d] = c_r1[d]; end
    @(posedge clk);
    #1;
    snap();
    for (int d = 0; d < 2; d++) begin
      o_fs[d] = c_fs[d]; o_g[d] = c_g[d]; o_l[d] = c_dac[d];
      o_ur[d] = c_ur[d]; o_cnt[d] = c_cnt[d]; o_stray[d] = 0;
    end
    for (int i = 1; i < H; i++) begin
      if (mid_chg && i == 3) begin mute = new_mute; src_en = new_en; end
      tick(); snap();
      for (int d = 0; d < 2; d++)
        if (c_dac[d] !== o_l[d] || c_fs[d] || c_ur[d] || c_r0[d] || c_r1[d] || c_g[d] !== o_g[d])
          o_stray[d]++;
    end
    lrc = 1'b1;
    for (int i = 0; i < H; i++) begin
      tick(); snap();
      for (int d = 0; d < 2; d++) begin
        if (i == 0) o_r[d] = c_dac[d];
        if (c_dac[d] !== o_r[d] || c_fs[d] || c_ur[d] || c_r0[d] || c_r1[d] || c_g[d] !== o_g[d])
          o_stray[d]++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lrc = 1'b1;
    model_reset();
    tick(); tick(); snap();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (c_dac[d] !== 16'h0 || c_g[d] !== 2'b00 || c_fs[d] !== 1'b0 || c_ur[d] !== 1'b0 ||
          c_cnt[d] != 0 || c_r0[d] !== 1'b0 || c_r1[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: got dac=%h g=%b fs=%b ur=%b cnt=%0d rdy=%b%b want all zero",
                 d, c_dac[d], c_g[d], c_fs[d], c_ur[d], c_cnt[d], c_r1[d], c_r0[d]);
      end
    end
    rst_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_single_source();
    src_en = 2'b01; v0 = 1'b1; v1 = 1'b0; l0 = 16'h1234; r0 = 16'hABCD;
    for (int k = 0; k < 4; k++) begin
      do_frame(1'b0, 1'b0, 2'b01);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_l[d] !== 16'h1234 || o_r[d] !== 16'hABCD) begin
          errors++;
          $display("FAIL single_data dut%0d f%0d: got %h/%h want 1234/abcd", d, k, o_l[d], o_r[d]);
        end
        checks++;
        if (o_r0[d] !== 1'b1 || o_r1[d] !== 1'b0 || o_g[d] !== 2'b01 || o_fs[d] !== 1'b1) begin
          errors++;
          $display("FAIL single_ctrl dut%0d f%0d: got rdy=%b%b g=%b fs=%b want rdy=01 g=01 fs=1",
                   d, k, o_r1[d], o_r0[d], o_g[d], o_fs[d]);
        end
        checks++;
        if (o_stray[d] != 0) begin
          errors++;
          $display("FAIL single_stable dut%0d f%0d: got %0d stray cycles want 0", d, k, o_stray[d]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  wg;
    logic [15:0] wl;
    src_en = 2'b11; v0 = 1'b1; v1 = 1'b1;
    l0 = 16'h1111; r0 = 16'h2222; l1 = 16'h3333; r1 = 16'h4444;
    for (int k = 0; k < 4; k++) begin
      do_frame(1'b0, 1'b0, 2'b11);
      wg = (k % 2 == 0) ? 2'b01 : 2'b10;
      wl = (k % 2 == 0) ? 16'h1111 : 16'h3333;
      checks++;
      if (o_g[1] !== wg || {o_r1[1], o_r0[1]} !== wg || o_l[1] !== wl) begin
        errors++;
        $display("FAIL rr_alt f%0d: got g=%b rdy=%b%b left=%h want g=%b left=%h",
                 k, o_g[1], o_r1[1], o_r0[1], o_l[1], wg, wl);
      end
      checks++;
      if (o_g[0] !== 2'b01 || o_r0[0] !== 1'b1 || o_r1[0] !== 1'b0 || o_l[0] !== 16'h1111) begin
        errors++;
        $display("FAIL fixed_prio f%0d: got g=%b rdy=%b%b left=%h want g=01 rdy=01 left=1111",
                 k, o_g[0], o_r1[0], o_r0[0], o_l[0]);
      end
    end
  endtask

  task automatic test_priority_drop();
    do_frame(1'b0, 1'b0, 2'b11);
    checks++;
    if (o_g[0] !== 2'b01) begin
      errors++;
      $display("FAIL prio_both: got g=%b want 01", o_g[0]);
    end
    v0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      do_frame(1'b0, 1'b0, 2'b11);
      checks++;
      if (o_g[0] !== 2'b10 || o_r1[0] !== 1'b1 || o_r0[0] !== 1'b0 ||
          o_l[0] !== 16'h3333 || o_r[0] !== 16'h4444) begin
        errors++;
        $display("FAIL prio_drop f%0d: got g=%b rdy=%b%b data=%h/%h want g=10 rdy=10 3333/4444",
                 k, o_g[0], o_r1[0], o_r0[0], o_l[0], o_r[0]);
      end
    end
  endtask

  task automatic test_underrun();
    int wa, wb;
    src_en = 2'b01; v0 = 1'b1; v1 = 1'b0; l0 = 16'h0100; r0 = 16'h0200;
    do_frame(1'b0, 1'b0, 2'b01);
    v0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      do_frame(1'b0, 1'b0, 2'b01);
      wa = k + 1;
      wb = (k + 1 > 3) ? 3 : k + 1;
      checks++;
      if (o_l[0] !== 16'h0100 || o_r[0] !== 16'h0200 || o_cnt[0] != wa) begin
        errors++;
        $display("FAIL ur_hold f%0d: got %h/%h cnt=%0d want 0100/0200 cnt=%0d",
                 k, o_l[0], o_r[0], o_cnt[0], wa);
      end
      checks++;
      if (o_l[1] !== 16'h0 || o_r[1] !== 16'h0 || o_cnt[1] != wb) begin
        errors++;
        $display("FAIL ur_zero f%0d: got %h/%h cnt=%0d want 0000/0000 cnt=%0d",
                 k, o_l[1], o_r[1], o_cnt[1], wb);
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_ur[d] !== 1'b1 || o_g[d] !== 2'b00 || o_r0[d] !== 1'b0 || o_r1[d] !== 1'b0) begin
          errors++;
          $display("FAIL ur_ctrl dut%0d f%0d: got ur=%b g=%b rdy=%b%b want ur=1 g=00 rdy=00",
                   d, k, o_ur[d], o_g[d], o_r1[d], o_r0[d]);
        end
      end
    end
    src_en = 2'b00; v0 = 1'b1;
    do_frame(1'b0, 1'b0, 2'b00);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_l[d] !== 16'h0 || o_r[d] !== 16'h0 || o_ur[d] !== 1'b0 || o_g[d] !== 2'b00 ||
          o_r0[d] !== 1'b0 || o_cnt[d] != ((d == 0) ? 4 : 3)) begin
        errors++;
        $display("FAIL idle dut%0d: got %h/%h ur=%b g=%b rdy0=%b cnt=%0d want zeros, cnt=%0d",
                 d, o_l[d], o_r[d], o_ur[d], o_g[d], o_r0[d], o_cnt[d], (d == 0) ? 4 : 3);
      end
    end
  endtask

  task automatic test_mute();
    src_en = 2'b01; v0 = 1'b1; v1 = 1'b0; l0 = 16'h7777; r0 = 16'h8888; mute = 1'b0;
    do_frame(1'b1, 1'b1, 2'b01);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_l[d] !== 16'h7777 || o_r[d] !== 16'h8888 || o_stray[d] != 0) begin
        errors++;
        $display("FAIL mute_mid dut%0d: got %h/%h stray=%0d want 7777/8888 stray=0",
                 d, o_l[d], o_r[d], o_stray[d]);
      end
    end
    do_frame(1'b0, 1'b1, 2'b01);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_l[d] !== 16'h0 || o_r[d] !== 16'h0 || o_r0[d] !== 1'b1 || o_g[d] !== 2'b01) begin
        errors++;
        $display("FAIL mute_on dut%0d: got %h/%h rdy0=%b g=%b want 0000/0000 rdy0=1 g=01",
                 d, o_l[d], o_r[d], o_r0[d], o_g[d]);
      end
    end
    mute = 1'b0;
  endtask

  task automatic test_watchdog();
    src_en = 2'b01; v0 = 1'b1; l0 = 16'h5A5A; r0 = 16'hA5A5;
    do_frame(1'b0, 1'b0, 2'b01);
    repeat (150) tick();
    snap();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (c_dac[d] !== 16'hA5A5 || c_g[d] !== 2'b01) begin
        errors++;
        $display("FAIL wd_early dut%0d: got dac=%h g=%b want a5a5 g=01", d, c_dac[d], c_g[d]);
      end
    end
    repeat (150) tick();
    snap();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (c_dac[d] !== 16'h0 || c_g[d] !== 2'b00 || c_r0[d] !== 1'b0) begin
        errors++;
        $display("FAIL wd_sync dut%0d: got dac=%h g=%b rdy0=%b want 0000 g=00 rdy0=0",
                 d, c_dac[d], c_g[d], c_r0[d]);
      end
    end
    l0 = 16'h1357; r0 = 16'h2468;
    do_frame(1'b0, 1'b0, 2'b01);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_g[d] !== 2'b01 || o_r0[d] !== 1'b1 || o_fs[d] !== 1'b1 ||
          o_l[d] !== 16'h1357 || o_r[d] !== 16'h2468) begin
        errors++;
        $display("FAIL wd_resume dut%0d: got g=%b rdy0=%b fs=%b %h/%h want 01 1 1 1357/2468",
                 d, o_g[d], o_r0[d], o_fs[d], o_l[d], o_r[d]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    src_en = 2'b01; v0 = 1'b1;
    lrc = 1'b0;
    #1;
    snap();
    checks++;
    if (c_r0[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_ready: got %b want 1", c_r0[0]);
    end
    rst_n = 1'b0;
    #1;
    snap();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (c_r0[d] !== 1'b0 || c_dac[d] !== 16'h0 || c_g[d] !== 2'b00 || c_cnt[d] != 0) begin
        errors++;
        $display("FAIL rst_mid dut%0d: got rdy0=%b dac=%h g=%b cnt=%0d want all zero",
                 d, c_r0[d], c_dac[d], c_g[d], c_cnt[d]);
      end
    end
    model_reset();
    lrc = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    src_en = 2'b11; v0 = 1'b1; v1 = 1'b1; l0 = 16'hAAAA; l1 = 16'hBBBB;
    do_frame(1'b0, 1'b0, 2'b11);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_g[d] !== 2'b01 || o_l[d] !== 16'hAAAA || o_cnt[d] != 0) begin
        errors++;
        $display("FAIL rst_after dut%0d: got g=%b left=%h cnt=%0d want g=01 aaaa cnt=0",
                 d, o_g[d], o_l[d], o_cnt[d]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      src_en = 2'($urandom_range(0, 3));
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      mute = ($urandom_range(0, 4) == 0);
      l0 = 16'($urandom); r0 = 16'($urandom); l1 = 16'($urandom); r1 = 16'($urandom);
      do_frame($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)));
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_g[d] !== e_g[d] || o_r0[d] !== e_g[d][0] || o_r1[d] !== e_g[d][1]) begin
          errors++;
          $display("FAIL rand_grant dut%0d f%0d: got g=%b rdy=%b%b want g=%b",
                   d, k, o_g[d], o_r1[d], o_r0[d], e_g[d]);
        end
        checks++;
        if (o_l[d] !== e_l[d] || o_r[d] !== e_r[d]) begin
          errors++;
          $display("FAIL rand_data dut%0d f%0d: got %h/%h want %h/%h",
                   d, k, o_l[d], o_r[d], e_l[d], e_r[d]);
        end
        checks++;
        if (o_ur[d] !== e_ur[d] || o_cnt[d] != e_cnt[d] || o_fs[d] !== 1'b1 || o_stray[d] != 0) begin
          errors++;
          $display("FAIL rand_status dut%0d f%0d: got ur=%b cnt=%0d fs=%b stray=%0d want ur=%b cnt=%0d fs=1 stray=0",
                   d, k, o_ur[d], o_cnt[d], o_fs[d], o_stray[d], e_ur[d], e_cnt[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_priority_drop();
    test_underrun();
    test_mute();
    test_watchdog();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
